// File: rtl/issue_replay_buffer.sv
// issue_replay_buffer
//   Dual-lane IF/ID issue register for the dual-issue pipeline. Latches the
//   fetched instruction pair, applies the per-lane IF/ID stall/flush masks,
//   queues pairs deferred by lane steering and re-issues them ahead of new
//   fetch. Drives `first` (lane 0 is program-order older) back to hazard
//   detection.
//
// Parameters:
//   REPLAY_DEPTH  deferred-pair FIFO entries (power of two, >= 2)
//   STATS_WIDTH   replay counter width
//
// Ports:
//   clk, reset                    clock, synchronous active-high reset
//   fetch_valid, *_in             fetched pair (instruction, pc, id per lane)
//   stall0/1, flush0/1            per-lane pipe masks, IF/ID bit only
//   defer_valid, defer_*          pair deferred by steering + its `first`
//   branch_flush                  mispredict, kills lanes and queue
//   *_out, first                  IF/ID register contents
//   fetch_hold                    fetch must not advance (combinational)
//   replay_overflow               sticky, a defer was dropped on a full queue
//   replay_count                  replayed pairs issued (saturating)
//
// Configuration macro: ISSUE_REPLAY_STATS_EN
//   defined   -> replay_count is a saturating counter of pops
//   undefined -> counter omitted, replay_count is constant 0

`ifndef INST_WIDTH
`define INST_WIDTH 32
`endif
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 32
`endif
`ifndef INSTRUCTION_ID_WIDTH
`define INSTRUCTION_ID_WIDTH 6
`endif
`ifndef NUM_PIPE_MASKS
`define NUM_PIPE_MASKS 5
`endif
`ifndef PIPE_REG_IF_ID
`define PIPE_REG_IF_ID 5'b00010
`endif

module issue_replay_buffer #(
  parameter int unsigned REPLAY_DEPTH = 2,
  parameter int unsigned STATS_WIDTH  = 16
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             fetch_valid,
  input  logic [`INST_WIDTH-1:0]           instruction0_in,
  input  logic [`INST_WIDTH-1:0]           instruction1_in,
  input  logic [`ADDR_WIDTH-1:0]           pc0_in,
  input  logic [`ADDR_WIDTH-1:0]           pc1_in,
  input  logic [`INSTRUCTION_ID_WIDTH-1:0] id0_in,
  input  logic [`INSTRUCTION_ID_WIDTH-1:0] id1_in,
  input  logic [`NUM_PIPE_MASKS-1:0]       stall0,
  input  logic [`NUM_PIPE_MASKS-1:0]       stall1,
  input  logic [`NUM_PIPE_MASKS-1:0]       flush0,
  input  logic [`NUM_PIPE_MASKS-1:0]       flush1,
  input  logic                             defer_valid,
  input  logic [`INST_WIDTH-1:0]           defer_instruction0,
  input  logic [`INST_WIDTH-1:0]           defer_instruction1,
  input  logic [`ADDR_WIDTH-1:0]           defer_pc0,
  input  logic [`ADDR_WIDTH-1:0]           defer_pc1,
  input  logic [`INSTRUCTION_ID_WIDTH-1:0] defer_id0,
  input  logic [`INSTRUCTION_ID_WIDTH-1:0] defer_id1,
  input  logic                             defer_first,
  input  logic                             branch_flush,
  output logic [`INST_WIDTH-1:0]           instruction0_out,
  output logic [`INST_WIDTH-1:0]           instruction1_out,
  output logic [`ADDR_WIDTH-1:0]           pc0_out,
  output logic [`ADDR_WIDTH-1:0]           pc1_out,
  output logic [`INSTRUCTION_ID_WIDTH-1:0] id0_out,
  output logic [`INSTRUCTION_ID_WIDTH-1:0] id1_out,
  output logic                             first,
  output logic                             fetch_hold,
  output logic                             replay_overflow,
  output logic [STATS_WIDTH-1:0]           replay_count
);

  localparam int unsigned PTR_W = (REPLAY_DEPTH > 1) ? $clog2(REPLAY_DEPTH) : 1;
  localparam int unsigned CNT_W = PTR_W + 1;

  typedef struct packed {
    logic [`INST_WIDTH-1:0]           inst;
    logic [`ADDR_WIDTH-1:0]           pc;
    logic [`INSTRUCTION_ID_WIDTH-1:0] id;
  } lane_t;

  typedef struct packed {
    lane_t lane1;
    lane_t lane0;
    logic  first;
  } entry_t;

  typedef enum logic {ST_RUN, ST_REPLAY} state_t;

  state_t           r_state, w_state_next;
  entry_t           r_fifo [REPLAY_DEPTH];
  logic [PTR_W-1:0] r_wr_ptr, r_rd_ptr;
  logic [CNT_W-1:0] r_count, w_count_next;
  lane_t            r_lane [2];
  logic             r_first;
  logic             r_overflow;

  logic             w_kill, w_empty, w_full, w_push, w_pop, w_fetch_load;
  logic [1:0]       w_stall, w_flush;
  lane_t            w_head [2];
  lane_t            w_fetch [2];
  entry_t           w_defer_entry;

  assign w_kill   = reset | branch_flush;
  assign w_empty  = (r_count == '0);
  assign w_full   = (r_count == CNT_W'(REPLAY_DEPTH));
  assign w_stall  = {|(stall1 & `PIPE_REG_IF_ID), |(stall0 & `PIPE_REG_IF_ID)};
  assign w_flush  = {|(flush1 & `PIPE_REG_IF_ID), |(flush0 & `PIPE_REG_IF_ID)};

  assign w_head[0]  = r_fifo[r_rd_ptr].lane0;
  assign w_head[1]  = r_fifo[r_rd_ptr].lane1;
  assign w_fetch[0] = '{inst: instruction0_in, pc: pc0_in, id: id0_in};
  assign w_fetch[1] = '{inst: instruction1_in, pc: pc1_in, id: id1_in};
  assign w_defer_entry = '{
    lane1: '{inst: defer_instruction1, pc: defer_pc1, id: defer_id1},
    lane0: '{inst: defer_instruction0, pc: defer_pc0, id: defer_id0},
    first: defer_first
  };

  // A pop needs both lanes free; a lane that loads the head while its partner
  // is stalled or flushed does not retire the entry.
  assign w_pop  = !w_kill && !w_empty && (w_stall == 2'b00) && (w_flush == 2'b00);
  assign w_push = !w_kill && defer_valid && !w_full;
  assign w_fetch_load = !w_kill && w_empty && fetch_valid &&
                        ((!w_stall[0] && !w_flush[0]) || (!w_stall[1] && !w_flush[1]));

  always_comb begin
    w_count_next = r_count;
    case ({w_push, w_pop})
      2'b10:   w_count_next = r_count + CNT_W'(1);
      2'b01:   w_count_next = r_count - CNT_W'(1);
      default: w_count_next = r_count;
    endcase
  end

  always_comb begin
    w_state_next = r_state;
    if (branch_flush) begin
      w_state_next = ST_RUN;
    end else begin
      case (r_state)
        ST_RUN:    if (w_push) w_state_next = ST_REPLAY;
        ST_REPLAY: if (w_pop && !w_push && (r_count == CNT_W'(1))) w_state_next = ST_RUN;
        default:   w_state_next = ST_RUN;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= ST_RUN;
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
    end else begin
      r_state <= w_state_next;
      if (branch_flush) begin
        r_wr_ptr <= '0;
        r_rd_ptr <= '0;
        r_count  <= '0;
      end else begin
        if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
        if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
        r_count <= w_count_next;
        if (defer_valid && w_full) r_overflow <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_fifo[r_wr_ptr] <= w_defer_entry;
  end

  always_ff @(posedge clk) begin
    for (int unsigned n = 0; n < 2; n++) begin
      if (w_kill || w_flush[n]) r_lane[n] <= '0;
      else if (w_stall[n])      r_lane[n] <= r_lane[n];
      else if (!w_empty)        r_lane[n] <= w_head[n];
      else if (fetch_valid)     r_lane[n] <= w_fetch[n];
      else                      r_lane[n] <= '0;
    end
  end

  always_ff @(posedge clk) begin
    if (w_kill)            r_first <= 1'b1;
    else if (w_pop)        r_first <= r_fifo[r_rd_ptr].first;
    else if (w_fetch_load) r_first <= 1'b1;
  end

`ifdef ISSUE_REPLAY_STATS_EN
  logic [STATS_WIDTH-1:0] r_replay_count;
  always_ff @(posedge clk) begin
    if (reset)                           r_replay_count <= '0;
    else if (w_pop && r_replay_count != '1) r_replay_count <= r_replay_count + STATS_WIDTH'(1);
  end
  assign replay_count = r_replay_count;
`else
  assign replay_count = '0;
`endif

  assign instruction0_out = r_lane[0].inst;
  assign instruction1_out = r_lane[1].inst;
  assign pc0_out          = r_lane[0].pc;
  assign pc1_out          = r_lane[1].pc;
  assign id0_out          = r_lane[0].id;
  assign id1_out          = r_lane[1].id;
  assign first            = r_first;
  assign fetch_hold       = defer_valid | (r_state == ST_REPLAY);
  assign replay_overflow  = r_overflow;

endmodule
